// File: rtl/updi_link_ctrl.sv
// rtl/updi_link_ctrl.sv - UPDI link controller: SYNC/LDCS/STCS/BREAK sequencing over phy FIFOs
// Optional feature: define UPDI_LINK_ECHO_CHECK_EN to compare echoed bytes with the bytes sent.
module updi_link_ctrl #(
   parameter int         RX_TIMEOUT_CLK = 200000,
   parameter logic [7:0] SYNC_BYTE      = 8'h55
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic [1:0] rsp_status,
   output logic [7:0] tx_data,
   output logic       tx_wr_en,
   input  logic       tx_full,
   input  logic [7:0] rx_data,
   output logic       rx_rd_en,
   input  logic       rx_empty,
   input  logic       rx_error,
   output logic       db_start,
   input  logic       db_busy,
   input  logic       db_done
);

   localparam logic [1:0]  OP_LDCS  = 2'b00;
   localparam logic [1:0]  OP_STCS  = 2'b01;
   localparam logic [1:0]  OP_BREAK = 2'b10;
   localparam logic [1:0]  ST_OK    = 2'b00;
   localparam logic [1:0]  ST_TMO   = 2'b01;
   localparam logic [1:0]  ST_RXERR = 2'b10;
   localparam logic [1:0]  ST_BAD   = 2'b11;
   localparam logic [31:0] TMO_LAST = 32'(RX_TIMEOUT_CLK - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_BREAK, S_TX, S_ECHO, S_RX, S_DRAIN, S_RESP
   } state_t;

   state_t      state_q;
   logic [1:0]  op_q;
   logic [3:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [1:0]  tx_idx_q;
   logic [1:0]  echo_idx_q;
   logic [31:0] tmo_q;
   logic        mism_q;
   logic [1:0]  status_q;
   logic [7:0]  rdata_q;
   logic        cmd_ready_q;
   logic        rsp_valid_q;
   logic        db_start_q;

   logic [1:0]  last_idx;
   logic        rx_live;
   logic        echo_bad;
   logic        unused_db_busy;

   // Byte n of the instruction frame: SYNC, opcode|addr, then STCS data.
   function automatic logic [7:0] seq_byte(input logic [1:0] idx, input logic [1:0] op,
                                           input logic [3:0] addr, input logic [7:0] wd);
      logic [7:0] b;
      case (idx)
         2'd0:    b = SYNC_BYTE;
         2'd1:    b = {(op == OP_STCS) ? 4'hC : 4'h8, addr};
         default: b = wd;
      endcase
      return b;
   endfunction

   // db_busy is informational only; break completion is taken from db_done.
   assign unused_db_busy = db_busy;

   assign last_idx  = (op_q == OP_STCS) ? 2'd2 : 2'd1;
   assign rx_live   = (state_q == S_ECHO) || (state_q == S_RX);
   assign tx_data   = seq_byte(tx_idx_q, op_q, addr_q, wdata_q);
   // Full gating is combinational so a write can never coincide with tx_full.
   assign tx_wr_en  = (state_q == S_TX) && !tx_full;
   // An rx_error cycle aborts without consuming the byte; DRAIN flushes it.
   assign rx_rd_en  = !rx_empty && ((rx_live && !rx_error) || (state_q == S_DRAIN));

`ifdef UPDI_LINK_ECHO_CHECK_EN
   assign echo_bad  = (rx_data != seq_byte(echo_idx_q, op_q, addr_q, wdata_q));
`else
   assign echo_bad  = 1'b0;
`endif

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rdata_q;
   assign rsp_status = status_q;
   assign db_start   = db_start_q;

   // Transaction sequencer: accept, transmit, consume echo/reply, respond.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LDCS;
         addr_q      <= 4'h0;
         wdata_q     <= 8'h00;
         tx_idx_q    <= 2'd0;
         echo_idx_q  <= 2'd0;
         tmo_q       <= 32'd0;
         mism_q      <= 1'b0;
         status_q    <= ST_OK;
         rdata_q     <= 8'h00;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         db_start_q  <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         db_start_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  op_q        <= cmd_op;
                  addr_q      <= cmd_addr;
                  wdata_q     <= cmd_wdata;
                  rdata_q     <= 8'h00;
                  status_q    <= ST_OK;
                  mism_q      <= 1'b0;
                  tx_idx_q    <= 2'd0;
                  echo_idx_q  <= 2'd0;
                  tmo_q       <= 32'd0;
                  if (cmd_op == OP_BREAK) begin
                     db_start_q <= 1'b1;
                     state_q    <= S_BREAK;
                  end else if (cmd_op == 2'b11) begin
                     status_q   <= ST_BAD;
                     state_q    <= S_RESP;
                  end else begin
                     state_q    <= S_TX;
                  end
               end
            end
            S_BREAK: begin
               if (db_done) state_q <= S_DRAIN;
            end
            S_TX: begin
               if (!tx_full) begin
                  if (tx_idx_q == last_idx) begin
                     tmo_q   <= 32'd0;
                     state_q <= S_ECHO;
                  end else begin
                     tx_idx_q <= tx_idx_q + 2'd1;
                  end
               end
            end
            S_ECHO, S_RX: begin
               if (rx_error) begin
                  status_q <= ST_RXERR;
                  state_q  <= S_DRAIN;
               end else if (!rx_empty) begin
                  tmo_q <= 32'd0;
                  if (state_q == S_RX) begin
                     rdata_q <= rx_data;
                     state_q <= S_RESP;
                  end else begin
                     if (echo_bad) mism_q <= 1'b1;
                     if (echo_idx_q == last_idx) begin
                        if (mism_q || echo_bad) begin
                           status_q <= ST_BAD;
                           state_q  <= S_DRAIN;
                        end else if (op_q == OP_LDCS) begin
                           state_q  <= S_RX;
                        end else begin
                           state_q  <= S_RESP;
                        end
                     end else begin
                        echo_idx_q <= echo_idx_q + 2'd1;
                     end
                  end
               end else if (tmo_q == TMO_LAST) begin
                  status_q <= ST_TMO;
                  state_q  <= S_DRAIN;
               end else begin
                  tmo_q <= tmo_q + 32'd1;
               end
            end
            S_DRAIN: begin
               if (rx_empty) state_q <= S_RESP;
            end
            S_RESP: begin
               rsp_valid_q <= 1'b1;
               cmd_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_updi_link_ctrl.sv
// tb/tb_updi_link_ctrl.sv - randomized bench for updi_link_ctrl with loopback phy model and scoreboard
module tb_updi_link_ctrl;

   localparam int TMO = 100;
`ifdef UPDI_LINK_ECHO_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [3:0] cmd_addr = 4'h0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic [1:0] rsp_status;
   logic [7:0] tx_data;
   logic       tx_wr_en;
   logic       tx_full = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rd_en;
   logic       rx_empty = 1'b1;
   logic       rx_error = 1'b0;
   logic       db_start;
   logic       db_busy = 1'b0;
   logic       db_done = 1'b0;

   updi_link_ctrl #(.RX_TIMEOUT_CLK(TMO), .SYNC_BYTE(8'h55)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
      .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_full(tx_full),
      .rx_data(rx_data), .rx_rd_en(rx_rd_en), .rx_empty(rx_empty), .rx_error(rx_error),
      .db_start(db_start), .db_busy(db_busy), .db_done(db_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // scenario knobs
   int         s_nbytes = 0;
   bit         s_tgt_en = 0;
   logic [7:0] s_tgt = 8'h00;
   int         s_corrupt = -1;
   int         s_err_rel = 0;
   int         s_full_from = 0;
   int         s_full_to = 0;
   bit         s_stall_rand = 0;
   int         s_db_delay = 10;
   int         s_garbage = 0;

   // phy / scoreboard state
   logic [7:0] rxq[$];
   logic [7:0] exp_tx[$];
   logic [7:0] tx_log[$];
   int         cyc = 0;
   int         c0 = 0;
   bit         accepted = 0;
   bit         pop_p = 0, wr_p = 0, dbs_p = 0;
   logic [7:0] wr_b = 8'h00;
   logic [7:0] phy_b;
   int         nwr = 0, npush = 0, npop = 0, nds = 0, nrsp = 0, db_cnt = 0;
   logic [1:0] exp_status = 2'b00;
   logic [7:0] exp_rdata = 8'h00;
   bit         exp_rdata_chk = 0;
   bit         rsp_expected = 0;
   int         last_lat = 0;
   logic [7:0] last_rdata = 8'h00;
   logic [1:0] last_status = 2'b00;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural expectation of one command, from the protocol rules.
   task automatic model(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wd);
      exp_tx.delete();
      if (op == 2'b00) begin
         exp_tx.push_back(8'h55);
         exp_tx.push_back(8'h80 | {4'h0, addr});
      end else if (op == 2'b01) begin
         exp_tx.push_back(8'h55);
         exp_tx.push_back(8'hC0 | {4'h0, addr});
         exp_tx.push_back(wd);
      end
      s_nbytes = exp_tx.size();
      if (op == 2'b11)                      exp_status = 2'b11;
      else if (op == 2'b10)                 exp_status = 2'b00;
      else if (s_err_rel != 0)              exp_status = 2'b10;
      else if (CHECK_EN && s_corrupt >= 0)  exp_status = 2'b11;
      else if (op == 2'b00 && !s_tgt_en)    exp_status = 2'b01;
      else                                  exp_status = 2'b00;
      exp_rdata_chk = (op != 2'b00) || (exp_status == 2'b00);
      exp_rdata     = (op == 2'b00 && exp_status == 2'b00) ? s_tgt : 8'h00;
   endtask

   // Phy model: TX sink with loopback echo, FWFT RX FIFO, double-break responder.
   always @(posedge clk) begin
      #1;
      if (pop_p && rxq.size() > 0) begin
         void'(rxq.pop_front());
         npop++;
      end
      if (wr_p) begin
         phy_b = wr_b;
         if (nwr == s_corrupt) phy_b = phy_b ^ 8'h01;
         rxq.push_back(phy_b);
         npush++;
         nwr++;
         if (nwr == s_nbytes && s_tgt_en) begin
            rxq.push_back(s_tgt);
            npush++;
         end
      end
      db_done = 1'b0;
      if (db_cnt > 0) begin
         db_cnt--;
         if (db_cnt == 0) db_done = 1'b1;
      end
      if (dbs_p) begin
         db_cnt = s_db_delay;
         for (int i = 0; i < s_garbage; i++) begin
            rxq.push_back(8'($urandom));
            npush++;
         end
      end
      db_busy  = (db_cnt > 0);
      tx_full  = (accepted && (cyc - c0) >= s_full_from && (cyc - c0) < s_full_to) ||
                 (s_stall_rand && $urandom_range(0, 3) == 0);
      rx_error = accepted && s_err_rel != 0 && (cyc - c0) == s_err_rel;
      rx_empty = (rxq.size() == 0);
      rx_data  = rx_empty ? 8'h00 : rxq[0];
   end

   // Compare process: every cycle, mid-period.
   always @(negedge clk) begin
      pop_p = rx_rd_en;
      wr_p  = tx_wr_en;
      wr_b  = tx_data;
      dbs_p = db_start;
      if (!rst) begin
         if (tx_wr_en) begin
            chk("tx_wr_while_full", {31'b0, tx_full}, 0);
            if (exp_tx.size() == 0) chk("tx_extra_write", {31'b0, tx_wr_en}, 0);
            else                    chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
            tx_log.push_back(tx_data);
         end
         if (rx_rd_en) chk("rx_pop_while_empty", {31'b0, rx_empty}, 0);
         if (db_start) nds++;
         if (rsp_valid) begin
            nrsp++;
            last_lat    = cyc - c0;
            last_rdata  = rsp_rdata;
            last_status = rsp_status;
            if (!rsp_expected) begin
               chk("rsp_unexpected", {31'b0, rsp_valid}, 0);
            end else begin
               chk("rsp_status", {30'b0, rsp_status}, {30'b0, exp_status});
               if (exp_rdata_chk) chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, exp_rdata});
               chk("rx_fifo_empty_at_rsp", rxq.size(), 0);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wd,
                        output bit ok);
      int n;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!cmd_ready && n < 20);
      chk("cmd_ready_wait", {31'b0, cmd_ready}, 1);
      ok = cmd_ready;
      if (ok) begin
         cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
         c0 = cyc; accepted = 1;
         @(posedge clk); #1;
         cmd_valid = 1'b0;
      end
   endtask

   task automatic run_txn(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wd);
      int n;
      bit ok;
      model(op, addr, wd);
      nwr = 0; npush = 0; npop = 0; nds = 0; nrsp = 0;
      tx_log.delete();
      rsp_expected = 1;
      issue(op, addr, wd, ok);
      if (ok) begin
         n = 0;
         while (nrsp == 0 && n < 600) begin
            @(posedge clk); #1;
            n++;
         end
         @(posedge clk); #1;
         chk("rsp_count", nrsp, 1);
         chk("tx_bytes_missing", exp_tx.size(), 0);
         chk("rx_pops_vs_pushed", npop, npush);
         chk("db_start_pulses", nds, (op == 2'b10) ? 1 : 0);
         chk("cmd_ready_after_rsp", {31'b0, cmd_ready}, 1);
      end
      rsp_expected = 0; accepted = 0;
      s_err_rel = 0; s_corrupt = -1; s_full_from = 0; s_full_to = 0;
      s_stall_rand = 0; s_garbage = 0; s_tgt_en = 0;
   endtask

   initial begin
      bit ok;
      logic [1:0] op;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 0);
      chk("rst_rsp_status", {30'b0, rsp_status}, 0);
      chk("rst_tx_wr_en", {31'b0, tx_wr_en}, 0);
      chk("rst_rx_rd_en", {31'b0, rx_rd_en}, 0);
      chk("rst_db_start", {31'b0, db_start}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("cmd_ready_first_cycle", {31'b0, cmd_ready}, 1);

      // STCS addr 3, data 59
      run_txn(2'b01, 4'h3, 8'h59);
      chk("stcs_status", {30'b0, last_status}, 0);
      chk("stcs_rdata", {24'b0, last_rdata}, 0);
      chk("stcs_nbytes", tx_log.size(), 3);
      chk("stcs_b0", {24'b0, tx_log[0]}, 32'h55);
      chk("stcs_b1", {24'b0, tx_log[1]}, 32'hC3);
      chk("stcs_b2", {24'b0, tx_log[2]}, 32'h59);

      // LDCS addr 0, reply 30, immediate echo
      s_tgt_en = 1; s_tgt = 8'h30;
      run_txn(2'b00, 4'h0, 8'h00);
      chk("ldcs_rdata", {24'b0, last_rdata}, 32'h30);
      chk("ldcs_status", {30'b0, last_status}, 0);
      chk("ldcs_b1", {24'b0, tx_log[1]}, 32'h80);
      chk("ldcs_latency_le7", {31'b0, last_lat <= 7}, 1);

      // LDCS with no reply: timeout
      run_txn(2'b00, 4'h5, 8'h00);
      chk("tmo_status", {30'b0, last_status}, 1);
      chk("tmo_latency_window", {31'b0, last_lat >= 100 && last_lat <= 112}, 1);

      // BREAK with db_done after 50 cycles and 2 glitch bytes
      s_db_delay = 50; s_garbage = 2;
      run_txn(2'b10, 4'h0, 8'h00);
      chk("break_status", {30'b0, last_status}, 0);
      chk("break_pops", npop, 2);
      chk("break_latency_ge50", {31'b0, last_lat >= 50}, 1);

      // STCS with tx_full held for 10 cycles after the first byte
      s_full_from = 2; s_full_to = 12;
      run_txn(2'b01, 4'h5, 8'hA7);
      chk("stall_status", {30'b0, last_status}, 0);
      chk("stall_b1", {24'b0, tx_log[1]}, 32'hC5);
      chk("stall_b2", {24'b0, tx_log[2]}, 32'hA7);
      chk("stall_latency_ge12", {31'b0, last_lat >= 12}, 1);

      // reserved op
      run_txn(2'b11, 4'h9, 8'h11);
      chk("rsvd_status", {30'b0, last_status}, 3);
      chk("rsvd_latency", last_lat, 2);
      chk("rsvd_no_tx", tx_log.size(), 0);

      // rx_error while waiting for reply
      s_err_rel = 20;
      run_txn(2'b00, 4'h1, 8'h00);
      chk("rxerr_status", {30'b0, last_status}, 2);

      // second echo byte corrupted to 81
      s_tgt_en = 1; s_tgt = 8'h42; s_corrupt = 1;
      run_txn(2'b00, 4'h0, 8'h00);
`ifdef UPDI_LINK_ECHO_CHECK_EN
      chk("corrupt_status", {30'b0, last_status}, 3);
`else
      chk("corrupt_rdata", {24'b0, last_rdata}, 32'h42);
`endif

      // reset in the middle of an LDCS
      model(2'b00, 4'h2, 8'h00);
      nrsp = 0; rsp_expected = 0;
      issue(2'b00, 4'h2, 8'h00, ok);
      repeat (20) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrst_cmd_ready", {31'b0, cmd_ready}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      accepted = 0;
      @(posedge clk); #1;
      chk("midrst_ready_after", {31'b0, cmd_ready}, 1);
      repeat (5) begin @(posedge clk); #1; end
      chk("midrst_no_rsp", nrsp, 0);

      // randomized traffic
      for (int t = 0; t < 40; t++) begin
         op = 2'($urandom_range(0, 3));
         s_tgt_en   = (op == 2'b00) && ($urandom_range(0, 4) != 0);
         s_tgt      = 8'($urandom);
         s_corrupt  = (op < 2'b10 && $urandom_range(0, 4) == 0) ?
                      $urandom_range(0, (op == 2'b01) ? 2 : 1) : -1;
         s_err_rel  = (op == 2'b00 && !s_tgt_en && s_corrupt < 0 && $urandom_range(0, 1) == 1) ?
                      20 + $urandom_range(0, 40) : 0;
         s_stall_rand = (s_err_rel == 0) && ($urandom_range(0, 1) == 1);
         s_db_delay = $urandom_range(1, 60);
         s_garbage  = $urandom_range(0, 3);
         run_txn(op, 4'($urandom), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
